// File: rtl/cv32e40p_lsu_obi.sv
// Data-side load/store unit driving an OBI bus (req/gnt address phase, rvalid response phase).
// Latency: address phase issued combinationally from lsu_en_i; load result combinational on the terminating rvalid.
// Backpressure: lsu_ready_ex_o low until the last address phase is granted; at most one bus transaction outstanding.
//
// Ports:
//   clk, rst_n                         core clock, async active-low reset
//   lsu_en_i/we_i/type_i/sign_ext_i    command from EX (type 00=word 01=half 10=byte 11=word)
//   addr_i, wdata_i                    byte address, LSB-aligned store data
//   wb_ready_i                         WB acceptance (no back-pressure path in this unit)
//   data_*                             OBI data bus
//   lsu_rdata_o/lsu_err_o              extended load result / 1-cycle error pulse
//   lsu_ready_ex_o/lsu_ready_wb_o      EX part done / no response pending
//   busy_o                             transaction outstanding or splitting
`default_nettype none
module cv32e40p_lsu_obi #(
  parameter bit PULP_OBI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_en_i,
  input  logic        we_i,
  input  logic [1:0]  type_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        wb_ready_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_ready_ex_o,
  output logic        lsu_ready_wb_o,
  output logic        lsu_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_RV1, REQ2, WAIT_RV2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d, type_q, type_d;
  logic        sign_q, sign_d, we_q, we_d, mis_q, mis_d, pend_q, pend_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, beat_q, beat_d;

  // The result is presented for exactly one cycle; WB readiness does not stall the bus side.
  logic wb_ready_unused;
  assign wb_ready_unused = wb_ready_i;

  // Byte enables of both phases: low nibble = phase 1, high nibble = phase 2.
  function automatic logic [7:0] be_span(input logic [1:0] t, input logic [1:0] o);
    logic [7:0] base;
    case (t)
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h01;
      default: base = 8'h0F;
    endcase
    return base << o;
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] d, input logic [1:0] o);
    logic [63:0] dd;
    dd = {d, d} << {o, 3'b000};
    return dd[63:32];
  endfunction

  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] o);
    case (t)
      2'b01:   return (o == 2'b11);
      2'b10:   return 1'b0;
      default: return (o != 2'b00);
    endcase
  endfunction

  logic        use_reg, cmd_vld, cmd_we, cmd_sign, cmd_mis, issue, rsp_term;
  logic [1:0]  cmd_type;
  logic [31:0] cmd_addr, cmd_wdata, wrot, rd_sh, ld_ext;
  logic [63:0] rd64;
  logic [7:0]  be8;

  always_comb begin
    // Strict OBI: a request left ungranted replays from the registers until granted.
    use_reg   = !PULP_OBI && pend_q;
    cmd_vld   = lsu_en_i | use_reg;
    cmd_addr  = use_reg ? {waddr_q, off_q} : addr_i;
    cmd_we    = use_reg ? we_q    : we_i;
    cmd_type  = use_reg ? type_q  : type_i;
    cmd_sign  = use_reg ? sign_q  : sign_ext_i;
    cmd_wdata = use_reg ? wdata_q : wdata_i;
    cmd_mis   = misaligned(cmd_type, cmd_addr[1:0]);

    // Load assembly from the latched access; only meaningful on a terminating rvalid.
    rd64  = mis_q ? {data_rdata_i, beat_q} : {32'b0, data_rdata_i};
    rd_sh = 32'(rd64 >> {off_q, 3'b000});
    case (type_q)
      2'b01:   ld_ext = {{16{sign_q & rd_sh[15]}}, rd_sh[15:0]};
      2'b10:   ld_ext = {{24{sign_q & rd_sh[7]}},  rd_sh[7:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    type_d  = type_q;
    sign_d  = sign_q;
    we_d    = we_q;
    mis_d   = mis_q;
    pend_d  = pend_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;

    data_req_o     = 1'b0;
    data_addr_o    = 32'b0;
    data_we_o      = 1'b0;
    data_be_o      = 4'b0;
    data_wdata_o   = 32'b0;
    lsu_rdata_o    = 32'b0;
    lsu_ready_ex_o = 1'b1;
    lsu_ready_wb_o = 1'b0;
    lsu_err_o      = 1'b0;
    issue          = 1'b0;
    rsp_term       = 1'b0;

    be8  = (state_q == REQ2) ? be_span(type_q, off_q) : be_span(cmd_type, cmd_addr[1:0]);
    wrot = (state_q == REQ2) ? rotl8(wdata_q, off_q)  : rotl8(cmd_wdata, cmd_addr[1:0]);

    case (state_q)
      IDLE: begin
        lsu_ready_wb_o = 1'b1;
        issue          = 1'b1;
      end
      WAIT_RV1: begin
        lsu_ready_ex_o = !lsu_en_i;
        if (data_rvalid_i) begin
          if (data_err_i) begin
            lsu_err_o = 1'b1;
            rsp_term  = 1'b1;
            state_d   = IDLE;
            // A split access still owns lsu_en_i: complete it with the error instead of reissuing it.
            if (mis_q) lsu_ready_ex_o = 1'b1;
            else       issue = 1'b1;
          end else if (mis_q) begin
            beat_d  = data_rdata_i;
            state_d = REQ2;
          end else begin
            rsp_term = 1'b1;
            state_d  = IDLE;
            issue    = 1'b1;
          end
        end
      end
      REQ2: begin
        data_req_o     = 1'b1;
        data_addr_o    = {waddr_q + 30'd1, 2'b00};
        data_we_o      = we_q;
        data_be_o      = be8[7:4];
        data_wdata_o   = wrot;
        lsu_ready_ex_o = data_gnt_i;
        if (data_gnt_i) state_d = WAIT_RV2;
      end
      WAIT_RV2: begin
        lsu_ready_ex_o = !lsu_en_i;
        if (data_rvalid_i) begin
          lsu_err_o = data_err_i;
          rsp_term  = 1'b1;
          state_d   = IDLE;
          issue     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_term) begin
      lsu_ready_wb_o = 1'b1;
      if (!we_q && !lsu_err_o) lsu_rdata_o = ld_ext;
    end

    // Issue a new command from IDLE or in the same cycle as a terminating response.
    if (issue) begin
      lsu_ready_ex_o = !cmd_vld | (data_gnt_i & !cmd_mis);
      if (cmd_vld) begin
        data_req_o   = 1'b1;
        data_addr_o  = {cmd_addr[31:2], 2'b00};
        data_we_o    = cmd_we;
        data_be_o    = be8[3:0];
        data_wdata_o = wrot;
        if (data_gnt_i || !PULP_OBI) begin
          off_d   = cmd_addr[1:0];
          type_d  = cmd_type;
          sign_d  = cmd_sign;
          we_d    = cmd_we;
          mis_d   = cmd_mis;
          waddr_d = cmd_addr[31:2];
          wdata_d = cmd_wdata;
          pend_d  = !data_gnt_i;
          if (data_gnt_i) state_d = WAIT_RV1;
        end
      end
    end

    // Reset drops the request and restores the idle handshake immediately.
    if (!rst_n) begin
      data_req_o     = 1'b0;
      data_addr_o    = 32'b0;
      data_we_o      = 1'b0;
      data_be_o      = 4'b0;
      data_wdata_o   = 32'b0;
      lsu_rdata_o    = 32'b0;
      lsu_ready_ex_o = 1'b1;
      lsu_ready_wb_o = 1'b1;
      lsu_err_o      = 1'b0;
    end
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= 2'b0;
      type_q  <= 2'b0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      pend_q  <= 1'b0;
      waddr_q <= 30'b0;
      wdata_q <= 32'b0;
      beat_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      pend_q  <= pend_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_lsu_obi.sv
// Scoreboard bench: the EX driver pushes expected bus beats and load results computed
// byte-by-byte from the access rules; a bus-slave/monitor process pops and compares them.
module tb_cv32e40p_lsu_obi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_en_i = 1'b0, we_i = 1'b0, sign_ext_i = 1'b0, wb_ready_i = 1'b1;
  logic [1:0]  type_i = 2'b0;
  logic [31:0] addr_i = 32'b0, wdata_i = 32'b0;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic [31:0] data_rdata_i = 32'b0;
  logic        data_req_o, data_we_o, lsu_ready_ex_o, lsu_ready_wb_o, lsu_err_o, busy_o;
  logic [31:0] data_addr_o, data_wdata_o, lsu_rdata_o;
  logic [3:0]  data_be_o;

  always #5 clk = ~clk;

  cv32e40p_lsu_obi dut (
    .clk(clk), .rst_n(rst_n), .lsu_en_i(lsu_en_i), .we_i(we_i), .type_i(type_i),
    .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .wb_ready_i(wb_ready_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_ready_ex_o(lsu_ready_ex_o), .lsu_ready_wb_o(lsu_ready_wb_o),
    .lsu_err_o(lsu_err_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we, err, skip, last;
    logic [3:0]  be;
    int          gw, rw;
  } beat_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  beat_t beats[$];
  rsp_t  rsps[$];
  int    n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- bus slave + monitor ----------------
  beat_t       cur;
  bit          pend = 0, gw_loaded = 0, hold_rv = 0, pw = 0;
  int          rw_left = 0, gw_left = 0, b2b_seen = 0;
  logic [31:0] pw_addr, pw_wdata;
  logic [3:0]  pw_be;
  logic        pw_we;

  initial forever begin
    @(negedge clk);
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = $urandom;
    data_gnt_i    = 1'b0;
    if (pend && !hold_rv) begin
      if (rw_left == 0) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = cur.rdata;
        data_err_i    = cur.err;
      end else rw_left--;
    end
    #1;
    if (data_req_o && beats.size() > 0) begin
      if (!gw_loaded) begin gw_left = beats[0].gw; gw_loaded = 1; end
      if (gw_left == 0) data_gnt_i = 1'b1;
      else gw_left--;
    end
    #2;
    if (pw) begin
      chk("hold_req",   {31'b0, data_req_o}, 32'd1);
      chk("hold_addr",  data_addr_o, pw_addr);
      chk("hold_be",    {28'b0, data_be_o}, {28'b0, pw_be});
      chk("hold_we",    {31'b0, data_we_o}, {31'b0, pw_we});
      chk("hold_wdata", data_wdata_o, pw_wdata);
    end
    pw = data_req_o && !data_gnt_i;
    pw_addr = data_addr_o; pw_be = data_be_o; pw_we = data_we_o; pw_wdata = data_wdata_o;

    // EX may only be released on the grant of a command's last beat, or on a phase-1 error.
    if (lsu_en_i && lsu_ready_ex_o && rst_n)
      chk("ready_ex_when",
          {31'b0, (data_req_o && data_gnt_i && beats.size() > 0 && beats[0].last) ||
                  (data_rvalid_i && pend && cur.err && cur.skip)}, 32'd1);

    if (data_rvalid_i) begin
      pend = 0;
      if (data_req_o && lsu_en_i) b2b_seen++;
      if (cur.err && cur.skip && beats.size() > 0) void'(beats.pop_front());
    end
    if (data_req_o && beats.size() == 0) chk("spurious_req", 32'd1, 32'd0);
    if (data_req_o && data_gnt_i && beats.size() > 0) begin
      beat_t b;
      b = beats.pop_front();
      chk("bus_addr", data_addr_o, b.addr);
      chk("bus_we",   {31'b0, data_we_o}, {31'b0, b.we});
      chk("bus_be",   {28'b0, data_be_o}, {28'b0, b.be});
      if (b.we) chk("bus_wdata", data_wdata_o, b.wdata);
      cur = b; pend = 1; rw_left = b.rw; gw_loaded = 0;
    end

    if (busy_o && lsu_ready_wb_o) begin
      if (rsps.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        rsp_t r;
        r = rsps.pop_front();
        chk("rsp_rdata", lsu_rdata_o, r.rdata);
        chk("rsp_err",   {31'b0, lsu_err_o}, {31'b0, r.err});
      end
    end else if (busy_o) begin
      chk("quiet_err",   {31'b0, lsu_err_o}, 32'd0);
      chk("quiet_rdata", lsu_rdata_o, 32'd0);
    end
  end

  // ---------------- EX driver with reference model ----------------
  task automatic do_cmd(input logic [31:0] a, input logic w, input logic [1:0] t, input logic s,
                        input logic [31:0] wd, input logic [31:0] r1, input logic [31:0] r2,
                        input logic e1, input logic e2, input int gw, input int rw);
    int          off, sz, lane, n;
    bit          mis;
    logic [3:0]  be0, be1;
    logic [31:0] ew, val;
    beat_t       b0, b1;
    rsp_t        r;
    off = int'(a[1:0]);
    sz  = (t == 2'b01) ? 2 : (t == 2'b10) ? 1 : 4;
    mis = (off + sz) > 4;
    be0 = 4'b0; be1 = 4'b0; ew = 32'b0; val = 32'b0;
    for (int k = 0; k < sz; k++) begin
      lane = (off + k) % 4;
      if (off + k < 4) begin be0[lane] = 1'b1; val[8*k +: 8] = r1[8*lane +: 8]; end
      else             begin be1[lane] = 1'b1; val[8*k +: 8] = r2[8*lane +: 8]; end
    end
    for (int j = 0; j < 4; j++) ew[8*((off + j) % 4) +: 8] = wd[8*j +: 8];
    if (s && sz < 4 && val[8*sz-1]) for (int i = 8*sz; i < 32; i++) val[i] = 1'b1;
    r.err   = e1 | (mis & e2);
    r.rdata = (r.err || w) ? 32'b0 : val;
    b0.addr = {a[31:2], 2'b00}; b0.wdata = ew; b0.rdata = r1; b0.we = w; b0.err = e1;
    b0.skip = mis; b0.last = !mis; b0.be = be0; b0.gw = gw; b0.rw = rw;
    beats.push_back(b0);
    if (mis) begin
      b1 = b0;
      b1.addr = {a[31:2], 2'b00} + 32'd4; b1.rdata = r2; b1.err = e2;
      b1.skip = 1'b0; b1.last = 1'b1; b1.be = be1;
      beats.push_back(b1);
    end
    rsps.push_back(r);
    addr_i = a; we_i = w; type_i = t; sign_ext_i = s; wdata_i = wd; lsu_en_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); #3;
      if (lsu_ready_ex_o) break;
      n++;
      if (n > 100) begin chk("accept_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
    lsu_en_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (beats.size() != 0 || rsps.size() != 0 || busy_o) begin
      @(posedge clk); #1;
      n++;
      if (n > 300) begin chk("idle_timeout", 32'd0, 32'd1); break; end
    end
  endtask

  initial begin
    int base;
    lsu_en_i = 1'b1; addr_i = 32'h1000;
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk("rst_req",      {31'b0, data_req_o},     32'd0);
    chk("rst_ready_ex", {31'b0, lsu_ready_ex_o}, 32'd1);
    chk("rst_ready_wb", {31'b0, lsu_ready_wb_o}, 32'd1);
    chk("rst_busy",     {31'b0, busy_o},         32'd0);
    chk("rst_err",      {31'b0, lsu_err_o},      32'd0);
    chk("rst_rdata",    lsu_rdata_o,             32'd0);
    @(posedge clk); #1;
    lsu_en_i = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_cmd(32'h0000_1000, 0, 2'b00, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    do_cmd(32'h0000_1003, 0, 2'b10, 1, 0, 32'h80FFFFFF, 0, 0, 0, 0, 0);
    do_cmd(32'h0000_1003, 0, 2'b10, 0, 0, 32'h80FFFFFF, 0, 0, 0, 0, 0);
    do_cmd(32'h0000_2002, 1, 2'b00, 0, 32'h11223344, 32'h5555AAAA, 32'h1234, 0, 0, 1, 1);
    do_cmd(32'h0FFF_FFFF, 0, 2'b01, 0, 0, 32'hAB000000, 32'h000000CD, 0, 0, 0, 0);
    do_cmd(32'hFFFF_FFFF, 0, 2'b01, 1, 0, 32'hAB000000, 32'h000000CD, 0, 0, 2, 1);
    do_cmd(32'h0000_3001, 0, 2'b00, 0, 0, 32'h01020304, 32'h05060708, 1, 0, 0, 0);
    do_cmd(32'h0000_3006, 0, 2'b00, 1, 0, 32'h81020304, 32'h85060708, 0, 1, 0, 0);
    do_cmd(32'h0000_300B, 0, 2'b11, 0, 0, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0, 0, 2);
    wait_idle();

    base = b2b_seen;
    do_cmd(32'h0000_4000, 0, 2'b00, 0, 0, 32'hA5A5A5A5, 0, 0, 0, 3, 0);
    do_cmd(32'h0000_4006, 0, 2'b01, 1, 0, 32'hF00D1234, 0, 0, 0, 3, 0);
    wait_idle();
    chk("back_to_back_req", {31'b0, b2b_seen > base}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      do_cmd(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();

    // Reset while a response is pending.
    hold_rv = 1;
    do_cmd(32'h0000_5000, 0, 2'b00, 0, 0, 32'h12345678, 0, 0, 0, 0, 0);
    lsu_en_i = 1'b1; addr_i = 32'h0000_6000; we_i = 1'b0; type_i = 2'b00;
    #1;
    chk("wait_busy",     {31'b0, busy_o},         32'd1);
    chk("wait_ready_ex", {31'b0, lsu_ready_ex_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_req",      {31'b0, data_req_o},     32'd0);
    chk("arst_ready_ex", {31'b0, lsu_ready_ex_o}, 32'd1);
    chk("arst_busy",     {31'b0, busy_o},         32'd0);
    chk("arst_ready_wb", {31'b0, lsu_ready_wb_o}, 32'd1);
    lsu_en_i = 1'b0;
    beats.delete(); rsps.delete();
    pend = 0; gw_loaded = 0; pw = 0; hold_rv = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(32'h0000_7002, 0, 2'b01, 1, 0, 32'h7FFF0000, 0, 0, 0, 1, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
